// File: rtl/dmac_distributor.sv
// Single-source to N-destination stream router. Each destination owns a one-entry
// output slot; beats addressed to a nonexistent destination are consumed and counted.
module dmac_distributor #(
  parameter int unsigned N_SLAVE   = 4,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ID_WIDTH  = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                src_valid_i,
  output logic                                src_ready_o,
  input  logic [ID_WIDTH-1:0]                 src_id_i,
  input  logic [DATA_SIZE-1:0]                src_data_i,
  output logic [N_SLAVE-1:0]                  dst_valid_o,
  input  logic [N_SLAVE-1:0]                  dst_ready_i,
  output logic [N_SLAVE-1:0][DATA_SIZE-1:0]   dst_data_o,
  output logic [15:0]                         drop_cnt_o,
  output logic                                busy_o
);

  logic [N_SLAVE-1:0]                valid_q, valid_d;
  logic [N_SLAVE-1:0][DATA_SIZE-1:0] data_q, data_d;
  logic [15:0]                       drop_cnt_q, drop_cnt_d;

  logic [N_SLAVE-1:0] id_sel;
  logic [N_SLAVE-1:0] slot_free;
  logic [N_SLAVE-1:0] slot_wr;
  logic               id_legal;
  logic               accept;

  // One-hot decode of the destination ID; all-zero when the ID is out of range.
  always_comb begin
    id_sel = '0;
    for (int unsigned k = 0; k < N_SLAVE; k++) begin
      id_sel[k] = (32'(src_id_i) == k);
    end
  end

  assign id_legal  = (32'(src_id_i) < N_SLAVE);
  assign slot_free = ~valid_q | dst_ready_i;

  // Ready never looks at src_valid_i, so a source may wait for ready before asserting valid.
  always_comb begin
    src_ready_o = 1'b0;
    if (!rst) begin
      src_ready_o = id_legal ? |(id_sel & slot_free) : 1'b1;
    end
  end

  assign accept  = src_valid_i & src_ready_o;
  assign slot_wr = id_sel & {N_SLAVE{accept}};

  // A write wins over a drain on the same slot, giving back-to-back beats with no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < N_SLAVE; k++) begin
      if (slot_wr[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = src_data_i;
      end else if (valid_q[k] && dst_ready_i[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !id_legal && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dst_valid_o = valid_q;
  assign dst_data_o  = data_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign busy_o      = |valid_q;

endmodule
